// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised write lanes,
// pending scoreboard and a soft-clear sweep. Define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_pending,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [XLEN-1:0]     wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [XLEN-1:0]     wr1_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                clr_req,
   output logic                clr_busy,
   output logic                clr_done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [AW-1:0] IDX_FIRST = (ZERO_REG != 0) ? AW'(1) : '0;
   localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_next;
   logic [1:0]      state;
   logic [AW-1:0]   idx;

   logic idle;
   logic clr_start;
   logic wr0_ok;
   logic wr1_ok;
   logic wr0_keep;
   logic iss_ok;

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Writeback and issue are only honoured while no sweep is in flight.
   assign idle      = (state == ST_IDLE);
   assign clr_start = idle && clr_req;
   assign wr0_ok    = idle && wr0_en && !is_zero_reg(wr0_addr);
   assign wr1_ok    = idle && wr1_en && !is_zero_reg(wr1_addr);
   assign wr0_keep  = wr0_ok && !(wr1_ok && (wr1_addr == wr0_addr));
   assign iss_ok    = idle && iss_en && !is_zero_reg(iss_addr);

   assign clr_busy  = (state == ST_SWEEP);
   assign clr_done  = (state == ST_DONE);

   // Issue is applied after the write clears so a new producer wins; a sweep start wipes everything.
   always_comb begin
      pend_next = pend;
      if (wr0_ok) pend_next[wr0_addr] = 1'b0;
      if (wr1_ok) pend_next[wr1_addr] = 1'b0;
      if (iss_ok) pend_next[iss_addr] = 1'b1;
      if (clr_start) pend_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend <= pend_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (clr_req) begin
                  state <= ST_SWEEP;
                  idx   <= IDX_FIRST;
               end
            end
            ST_SWEEP: begin
               if (idx == IDX_LAST) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // wr1 is written last so it overrides wr0 on an address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (state == ST_SWEEP) begin
         regs[idx] <= '0;
      end else begin
         if (wr0_keep) regs[wr0_addr] <= wr0_data;
         if (wr1_ok)   regs[wr1_addr] <= wr1_data;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            pnd;

      assign a = rd_addr[p*AW +: AW];

      always_comb begin
         d   = regs[a];
         pnd = pend[a];
`ifdef REGFILE_MP_BYPASS_EN
         if (wr1_ok && (wr1_addr == a)) begin
            d   = wr1_data;
            pnd = iss_ok && (iss_addr == a);
         end else if (wr0_ok && (wr0_addr == a)) begin
            d   = wr0_data;
            pnd = iss_ok && (iss_addr == a);
         end
`endif
         if (is_zero_reg(a)) begin
            d   = '0;
            pnd = 1'b0;
         end
      end

      assign rd_data[p*XLEN +: XLEN] = d;
      assign rd_pending[p]           = pnd;
   end

endmodule
